// File: rtl/proc_pkg.sv
// Shared processor definitions: opcodes, instruction field positions, sequencer
// state encoding and the decoded-instruction record.
package proc_pkg;

  localparam int INSTR_W = 16;
  localparam int DATA_W  = 32;
  localparam int OP_W    = 4;
  localparam int REG_W   = 4;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;

  localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
  localparam logic [OP_W-1:0] OP_AND  = 4'h2;
  localparam logic [OP_W-1:0] OP_OR   = 4'h3;
  localparam logic [OP_W-1:0] OP_XOR  = 4'h4;
  localparam logic [OP_W-1:0] OP_SL   = 4'h5;
  localparam logic [OP_W-1:0] OP_SRL  = 4'h6;
  localparam logic [OP_W-1:0] OP_SRA  = 4'h7;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_HALTED
  } seq_state_e;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             is_alu;
    logic             is_halt;
  } dec_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction-word splitter; classifies ALU ops (0..7) and HALT.
module instr_decoder
  import proc_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output dec_t               dec
);

  always_comb begin
    dec         = '0;
    dec.op      = ir[OP_MSB:OP_LSB];
    dec.rd      = ir[RD_MSB:RD_LSB];
    dec.rs1     = ir[RS1_MSB:RS1_LSB];
    dec.rs2     = ir[RS2_MSB:RS2_LSB];
    dec.is_alu  = (dec.op <= OP_SRA);
    dec.is_halt = (dec.op == OP_HALT);
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute/writeback sequencer driving register_bank and alu.
// All register-bank and ALU-facing outputs are registered.
module instr_sequencer
  import proc_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [REG_W-1:0]   read_reg1,
  output logic [REG_W-1:0]   read_reg2,
  output logic [REG_W-1:0]   write_reg,
  output logic [DATA_W-1:0]  write_data,
  output logic               write_enable,
  output logic [OP_W-1:0]    alu_opcode,
  input  logic [DATA_W-1:0]  alu_result,
  output logic               busy,
  output logic               halted,
  output logic [CNT_W-1:0]   instr_count
);

  seq_state_e           state_q, state_d;
  logic [PC_W-1:0]      pc;
  logic [INSTR_W-1:0]   ir;
  dec_t                 dec;

  instr_decoder u_dec (
    .ir  (ir),
    .dec (dec)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE,
      ST_HALTED:    if (start) state_d = ST_FETCH;
      ST_FETCH:     state_d = ST_DECODE;
      ST_DECODE:    state_d = dec.is_halt ? ST_HALTED : ST_EXECUTE;
      ST_EXECUTE:   state_d = ST_WRITEBACK;
      ST_WRITEBACK: state_d = ST_FETCH;
      default:      state_d = ST_IDLE;
    endcase
  end

  // write_enable is a one-cycle strobe: cleared every cycle unless EXECUTE arms it
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= '0;
      ir           <= '0;
      read_reg1    <= '0;
      read_reg2    <= '0;
      write_reg    <= '0;
      alu_opcode   <= '0;
      write_data   <= '0;
      write_enable <= 1'b0;
      instr_count  <= '0;
    end else begin
      write_enable <= 1'b0;
      case (state_q)
        ST_IDLE,
        ST_HALTED: if (start) begin
          pc          <= '0;
          instr_count <= '0;
        end
        ST_FETCH:  ir <= imem_data;
        ST_DECODE: begin
          read_reg1  <= dec.rs1;
          read_reg2  <= dec.rs2;
          write_reg  <= dec.rd;
          alu_opcode <= dec.op;
        end
        ST_EXECUTE: begin
          write_data   <= alu_result;
          write_enable <= dec.is_alu;
        end
        ST_WRITEBACK: begin
          pc <= pc + PC_W'(1);
          if (instr_count != {CNT_W{1'b1}}) instr_count <= instr_count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign imem_addr = pc;
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                     (state_q == ST_EXECUTE) || (state_q == ST_WRITEBACK);
  assign halted    = (state_q == ST_HALTED);

endmodule
